// File: rtl/snes_poll_master.sv
// Console-side poller for SNES/NES-style serial pads: drives latch/clock and
// deserialises NUM_PORTS data lines into a frame register, free-running or single-shot.
module snes_poll_master #(
    parameter int PERIOD_CYCLES = 800000,
    parameter int LATCH_CYCLES  = 576,
    parameter int HALF_CYCLES   = 288,
    parameter int NUM_BITS      = 16,
    parameter int NUM_PORTS     = 2,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           trigger,
    input  logic [NUM_PORTS-1:0]           data_in,
    output logic                           snes_lat,
    output logic                           snes_clk,
    output logic [NUM_PORTS*NUM_BITS-1:0]  frame_data,
    output logic                           frame_valid,
    output logic                           busy,
    output logic [15:0]                    frame_count
);

    localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(PERIOD_CYCLES + 1);
    localparam int BW   = $clog2(NUM_BITS + 1);

    typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_LO, CLK_HI} state_t;

    state_t                          r_state, w_next;
    logic [CW-1:0]                   r_cnt;
    logic [PW-1:0]                   r_period;
    logic [BW-1:0]                   r_bit;
    logic [BW-1:0]                   w_idx;
    logic                            r_en_d, r_pend;
    logic [NUM_PORTS*NUM_BITS-1:0]   r_shadow;
    logic                            w_tc_lat, w_tc_half, w_last, w_due;
    logic                            w_start, w_done, w_sample;

    assign w_tc_lat  = (r_cnt == CW'(LATCH_CYCLES - 1));
    assign w_tc_half = (r_cnt == CW'(HALF_CYCLES - 1));
    assign w_last    = (r_bit == BW'(NUM_BITS - 1));
    // An enable rising edge counts as an expired period; if it lands mid-frame it is held pending.
    assign w_due     = enable && ((r_period == PW'(PERIOD_CYCLES - 1)) || !r_en_d || r_pend);
    assign w_idx     = (r_state == LATCH) ? '0 : r_bit + 1'b1;

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_done   = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            IDLE: begin
                if (trigger || w_due) begin
                    w_next  = LATCH;
                    w_start = 1'b1;
                end
            end
            LATCH: begin
                if (w_tc_lat) begin
                    w_next   = GAP;
                    w_sample = 1'b1;
                end
            end
            GAP: begin
                if (w_tc_half) w_next = CLK_LO;
            end
            CLK_LO: begin
                if (w_tc_half) w_next = CLK_HI;
            end
            CLK_HI: begin
                if (w_tc_half) begin
                    if (w_last) begin
                        w_next = IDLE;
                        w_done = 1'b1;
                    end else begin
                        w_next   = CLK_LO;
                        w_sample = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_period    <= '0;
            r_bit       <= '0;
            r_en_d      <= 1'b0;
            r_pend      <= 1'b0;
            snes_lat    <= 1'b0;
            snes_clk    <= 1'b1;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            r_en_d      <= enable;

            if (!enable || w_start)
                r_period <= '0;
            else if (r_period != PW'(PERIOD_CYCLES - 1))
                r_period <= r_period + 1'b1;

            if (!enable || w_start)
                r_pend <= 1'b0;
            else if (!r_en_d && r_state != IDLE)
                r_pend <= 1'b1;

            if (r_state == IDLE || w_next != r_state)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            // The pad clock is low only for the CLK_LO phase, so it follows the next state directly.
            snes_clk <= (w_next != CLK_LO);

            if (w_start) begin
                snes_lat <= 1'b1;
                busy     <= 1'b1;
                r_bit    <= '0;
            end else if (r_state == LATCH && w_tc_lat) begin
                snes_lat <= 1'b0;
            end

            if (r_state == CLK_HI && w_tc_half && !w_last)
                r_bit <= r_bit + 1'b1;

            if (w_done) begin
                frame_data  <= r_shadow;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
                busy        <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int i = 0; i < NUM_BITS; i++) begin
                if (w_sample && i == int'(w_idx))
                    r_shadow[p*NUM_BITS + i] <= data_in[p] ^ ACTIVE_LOW;
            end
        end
    end

endmodule
